lenet_argmax: RTL and testbench

Classification output stage placed directly downstream of the third LeNet-5 layer. It captures the ten signed 32-bit class scores when the layer's `ready` rises and scans them sequentially, one comparison per cycle. It then reports the winning class index and its score with a one-cycle `valid` pulse. This turns the network's raw score vector into a single decision for the surrounding system.

---
 rtl/lenet_argmax.sv | 209 ++++++++++++++++++++
 tb/tb_lenet_argmax.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_argmax.sv
// rtl/lenet_argmax.sv - sequential argmax over the ten LeNet-5 class scores
//
// Purpose:
//   Captures ten signed class scores on a rising edge of the layer-3 ready
//   signal and scans them one comparison per clock. It then publishes the
//   winning class index and its score together with a one-cycle valid pulse.
//   Ties resolve to the lowest index.
//
// Optional feature:
//   LENET_ARGMAX_OVERRUN_EN - adds a sticky 'overrun' output. It flags a
//   start edge that arrived while a capture/scan was still in progress.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   ready_in       in   layer-3 ready; 0->1 transition starts a capture
//   score0..score9 in   signed SCORE_W-bit class scores
//   class_idx      out  index of the maximum score, held until next result
//   max_score      out  maximum score value, held until next result
//   valid          out  one-cycle pulse when class_idx/max_score update
//   busy           out  high while capture/scan is in progress
//   overrun        out  sticky start-while-busy flag (LENET_ARGMAX_OVERRUN_EN only)

module lenet_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 32,
  parameter int IDX_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ready_in,
  input  logic signed [SCORE_W-1:0] score0,
  input  logic signed [SCORE_W-1:0] score1,
  input  logic signed [SCORE_W-1:0] score2,
  input  logic signed [SCORE_W-1:0] score3,
  input  logic signed [SCORE_W-1:0] score4,
  input  logic signed [SCORE_W-1:0] score5,
  input  logic signed [SCORE_W-1:0] score6,
  input  logic signed [SCORE_W-1:0] score7,
  input  logic signed [SCORE_W-1:0] score8,
  input  logic signed [SCORE_W-1:0] score9,
  output logic        [IDX_W-1:0]   class_idx,
  output logic signed [SCORE_W-1:0] max_score,
  output logic                      valid,
  output logic                      busy
`ifdef LENET_ARGMAX_OVERRUN_EN
  ,
  output logic                      overrun
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLASSES - 1);

  // Control state
  logic [1:0]                state_q,     state_d;
  logic                      ready_dly_q, ready_dly_d;
  logic [IDX_W-1:0]          idx_q,       idx_d;
  logic                      busy_q,      busy_d;

  // Running best during the scan
  logic signed [SCORE_W-1:0] best_q,      best_d;
  logic [IDX_W-1:0]          best_idx_q,  best_idx_d;

  // Published result
  logic [IDX_W-1:0]          class_idx_q, class_idx_d;
  logic signed [SCORE_W-1:0] max_score_q, max_score_d;
  logic                      valid_q,     valid_d;

  // Snapshot of the scores taken at the start edge; the live inputs are
  // free to change once the capture has happened.
  logic signed [SCORE_W-1:0] score_buf_q [NUM_CLASSES];
  logic signed [SCORE_W-1:0] score_buf_d [NUM_CLASSES];

  logic                      start;

`ifdef LENET_ARGMAX_OVERRUN_EN
  logic                      overrun_q,   overrun_d;
`endif

  assign start = ready_in & ~ready_dly_q;

  always_comb begin
    state_d     = state_q;
    ready_dly_d = ready_in;
    idx_d       = idx_q;
    busy_d      = busy_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_idx_d = class_idx_q;
    max_score_d = max_score_q;
    valid_d     = 1'b0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      score_buf_d[k] = score_buf_q[k];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          score_buf_d[0] = score0;
          score_buf_d[1] = score1;
          score_buf_d[2] = score2;
          score_buf_d[3] = score3;
          score_buf_d[4] = score4;
          score_buf_d[5] = score5;
          score_buf_d[6] = score6;
          score_buf_d[7] = score7;
          score_buf_d[8] = score8;
          score_buf_d[9] = score9;
          // Entry 0 seeds the running best, so the scan starts at entry 1.
          best_d     = score0;
          best_idx_d = IDX_ZERO;
          idx_d      = IDX_ONE;
          busy_d     = 1'b1;
          state_d    = ST_SCAN;
        end
      end

      ST_SCAN: begin
        // Strict greater-than keeps the earliest index on ties.
        if (score_buf_q[idx_q] > best_q) begin
          best_d     = score_buf_q[idx_q];
          best_idx_d = idx_q;
        end
        if (idx_q == IDX_LAST) begin
          idx_d   = IDX_ZERO;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      ST_DONE: begin
        class_idx_d = best_idx_q;
        max_score_d = best_q;
        valid_d     = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end

      default: begin
        idx_d   = IDX_ZERO;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef LENET_ARGMAX_OVERRUN_EN
  always_comb begin
    overrun_d = overrun_q;
    if (start && busy_q) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_dly_q <= 1'b0;
      idx_q       <= IDX_ZERO;
      busy_q      <= 1'b0;
      best_q      <= '0;
      best_idx_q  <= IDX_ZERO;
      class_idx_q <= IDX_ZERO;
      max_score_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_dly_q <= ready_dly_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_idx_q <= class_idx_d;
      max_score_q <= max_score_d;
      valid_q     <= valid_d;
    end
  end

  // The score buffer is only ever read after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      score_buf_q[k] <= score_buf_d[k];
    end
  end

  assign class_idx = class_idx_q;
  assign max_score = max_score_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lenet_argmax.sv
// tb/tb_lenet_argmax.sv - self-checking bench for lenet_argmax
module tb_lenet_argmax;

  logic               clk;
  logic               rst;
  logic               ready_in;
  logic signed [31:0] sc [10];
  logic        [3:0]  class_idx;
  logic signed [31:0] max_score;
  logic               valid;
  logic               busy;
`ifdef LENET_ARGMAX_OVERRUN_EN
  logic               overrun;
`endif

  int n_total = 0;
  int n_pass  = 0;

  lenet_argmax dut (
    .clk       (clk),
    .rst       (rst),
    .ready_in  (ready_in),
    .score0    (sc[0]),
    .score1    (sc[1]),
    .score2    (sc[2]),
    .score3    (sc[3]),
    .score4    (sc[4]),
    .score5    (sc[5]),
    .score6    (sc[6]),
    .score7    (sc[7]),
    .score8    (sc[8]),
    .score9    (sc[9]),
    .class_idx (class_idx),
    .max_score (max_score),
    .valid     (valid),
    .busy      (busy)
`ifdef LENET_ARGMAX_OVERRUN_EN
    ,
    .overrun   (overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: find the maximum value, then the first index holding it.
  task automatic model(output logic [3:0] idx, output logic signed [31:0] best);
    best = sc[0];
    foreach (sc[k]) if (sc[k] > best) best = sc[k];
    idx = 4'd0;
    for (int k = 9; k >= 0; k--) if (sc[k] == best) idx = 4'(k);
  endtask

  task automatic rand_scores(input int mode);
    foreach (sc[k]) begin
      if (mode == 0) sc[k] = $urandom();
      else           sc[k] = 32'(int'($urandom_range(0, 6)) - 3);
    end
  endtask

  // Entered at a negedge with ready_in low for at least one edge. Raises
  // ready_in, checks busy/valid every cycle and the result, then drops ready.
  // With mutate set, the live scores are rerandomised right after capture.
  task automatic run_scan(input string tag, input bit mutate);
    logic [3:0]         e_idx;
    logic signed [31:0] e_best;
    model(e_idx, e_best);
    ready_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk({tag, " busy"}, busy, 1'b1);
      chk({tag, " valid_early"}, valid, 1'b0);
      if (mutate && k == 1) rand_scores(0);
    end
    @(negedge clk);
    chk({tag, " valid"}, valid, 1'b1);
    chk({tag, " busy_done"}, busy, 1'b0);
    chk({tag, " class_idx"}, class_idx, e_idx);
    chk({tag, " max_score"}, max_score, e_best);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, " valid_hold"}, valid, 1'b0);
      chk({tag, " idx_hold"}, class_idx, e_idx);
    end
    ready_in = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    logic [3:0]         e_idx, e_idx2;
    logic signed [31:0] e_best, e_best2;

    rst = 1'b1;
    ready_in = 1'b0;
    foreach (sc[k]) sc[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst class_idx", class_idx, 4'd0);
    chk("rst max_score", max_score, 32'd0);
    chk("rst valid", valid, 1'b0);
    chk("rst busy", busy, 1'b0);
`ifdef LENET_ARGMAX_OVERRUN_EN
    chk("rst overrun", overrun, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Ascending scores
    foreach (sc[k]) sc[k] = 32'(10 * k);
    run_scan("ascend", 1'b0);
    chk("ascend idx9", class_idx, 4'd9);
    chk("ascend max90", max_score, 32'd90);

    // Negative scores
    sc[0] = -5; sc[1] = -3; sc[2] = -100; sc[3] = 32'h80000000; sc[4] = -7;
    sc[5] = -4; sc[6] = -9; sc[7] = -3000; sc[8] = -6; sc[9] = -8;
    run_scan("negative", 1'b0);
    chk("negative idx1", class_idx, 4'd1);
    chk("negative max-3", max_score, -32'sd3);

    // Tie: lowest index wins
    foreach (sc[k]) sc[k] = '0;
    sc[3] = 1000; sc[7] = 1000;
    run_scan("tie", 1'b0);
    chk("tie idx3", class_idx, 4'd3);

    // Inputs change one cycle after capture
    foreach (sc[k]) sc[k] = '0;
    sc[5] = 500;
    ready_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sc[5] = 0; sc[2] = 900;
    repeat (9) @(negedge clk);
    chk("late_change valid", valid, 1'b1);
    chk("late_change idx5", class_idx, 4'd5);
    chk("late_change max500", max_score, 32'd500);
    ready_in = 1'b0;
    @(negedge clk);

    // Reset mid-scan at E5: no valid afterwards, outputs cleared
    foreach (sc[k]) sc[k] = 32'(10 * k);
    ready_in = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    ready_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("midrst valid", valid, 1'b0);
      chk("midrst busy", busy, 1'b0);
      chk("midrst class_idx", class_idx, 4'd0);
      chk("midrst max_score", max_score, 32'd0);
    end
    run_scan("after_rst", 1'b0);
    chk("after_rst idx9", class_idx, 4'd9);

`ifdef LENET_ARGMAX_OVERRUN_EN
    chk("overrun clear", overrun, 1'b0);
`endif

    // Overrun: restart edge at E4 is ignored
    rand_scores(0);
    model(e_idx, e_best);
    ready_in = 1'b1;
    repeat (3) @(negedge clk);
    ready_in = 1'b0;
    foreach (sc[k]) sc[k] = 32'sh7fffffff - 32'(k);
    @(negedge clk);
    ready_in = 1'b1;
    @(negedge clk);
    chk("overrun busy", busy, 1'b1);
`ifdef LENET_ARGMAX_OVERRUN_EN
    chk("overrun set", overrun, 1'b1);
`endif
    repeat (6) @(negedge clk);
    chk("overrun valid", valid, 1'b1);
    chk("overrun class_idx", class_idx, e_idx);
    chk("overrun max_score", max_score, e_best);
    // ready_in held high: no further result
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("held valid", valid, 1'b0);
      chk("held busy", busy, 1'b0);
    end
`ifdef LENET_ARGMAX_OVERRUN_EN
    chk("overrun sticky", overrun, 1'b1);
`endif
    ready_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef LENET_ARGMAX_OVERRUN_EN
    chk("overrun rst", overrun, 1'b0);
`endif
    @(negedge clk);

    // Back-to-back: start in the valid cycle is accepted
    rand_scores(0);
    model(e_idx, e_best);
    ready_in = 1'b1;
    repeat (10) @(negedge clk);
    ready_in = 1'b0;
    @(negedge clk);
    chk("b2b valid1", valid, 1'b1);
    chk("b2b idx1", class_idx, e_idx);
    chk("b2b max1", max_score, e_best);
    rand_scores(1);
    model(e_idx2, e_best2);
    ready_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("b2b busy2", busy, 1'b1);
      chk("b2b valid2_early", valid, 1'b0);
    end
    @(negedge clk);
    chk("b2b valid2", valid, 1'b1);
    chk("b2b idx2", class_idx, e_idx2);
    chk("b2b max2", max_score, e_best2);
    ready_in = 1'b0;
    @(negedge clk);

    // Randomised vectors: full range, tie-heavy, and post-capture mutation
    for (int t = 0; t < 24; t++) begin
      rand_scores(t % 2);
      run_scan($sformatf("rand%0d", t), (t % 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
